// File: rtl/spu_pc_fetch_ctrl_pkg.sv
// Shared pipeline-front definitions: reset/branch polarity, fetch FSM encoding, LS address mask.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: RST_ENABLE, BRANCH, fetch_state_t, ls_addr_mask().
package spu_pc_fetch_ctrl_pkg;

  // Active level of the synchronous pipeline reset.
  localparam logic RST_ENABLE = 1'b1;

  // Active level of the taken-branch strobe from FF4.
  localparam logic BRANCH = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_t;

  // Byte-address mask that keeps an address inside local store and aligned
  // to a fetch group: low log2(fetch_bytes) bits and bits >= ls_bits cleared.
  function automatic logic [31:0] ls_addr_mask(input int unsigned ls_bits,
                                               input int unsigned fetch_bytes);
    logic [31:0] m;
    m = (32'd1 << ls_bits) - 32'd1;
    m = m & ~(fetch_bytes[31:0] - 32'd1);
    return m;
  endfunction

endpackage

// File: rtl/spu_flush_timer.sv
// Flush-window down-counter: load, decrement while enabled, flag zero.
// Latency: load/decrement visible 1 cycle later; zero is a decode of the current count.
// Backpressure: none; load always wins over decrement, count saturates at 0.
// Ports: clk, rst (sync, active-high), load, load_val[2:0], dec, zero.
module spu_flush_timer
  import spu_pc_fetch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/spu_pc_fetch_ctrl.sv
// PC / fetch-request controller: issues FETCH_BYTES-aligned local-store fetches, applies FF4 redirects and flushes.
// Latency: redirect at cycle N -> o_flush N+1..N+FLUSH_CYCLES -> target fetch valid at N+FLUSH_CYCLES+1.
// Backpressure: PC advances only on o_fetch_valid & i_fetch_ready without i_stall; otherwise the request is held.
// Ports: clk, rst | i_branch_flag, i_branch_target_addr[31:0], i_is_in_delayslot, i_stall, i_fetch_ready |
//        o_fetch_valid, o_pc[31:0], o_slot0_kill, o_flush, o_next_in_delayslot, o_branch_ignored (all registered).
module spu_pc_fetch_ctrl
  import spu_pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FETCH_BYTES  = 8,
  parameter int          LS_ADDR_BITS = 18,
  parameter int          FLUSH_CYCLES = 3
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_branch_flag,
  input  logic [31:0] i_branch_target_addr,
  input  logic        i_is_in_delayslot,
  input  logic        i_stall,
  input  logic        i_fetch_ready,
  output logic        o_fetch_valid,
  output logic [31:0] o_pc,
  output logic        o_slot0_kill,
  output logic        o_flush,
  output logic        o_next_in_delayslot,
  output logic        o_branch_ignored
);

  localparam logic [31:0] ADDR_MASK  = ls_addr_mask(LS_ADDR_BITS, FETCH_BYTES);
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  fetch_state_t state, state_d;

  logic [31:0] target_q, target_d;
  logic        kill_pend_q, kill_pend_d;
  logic [31:0] pc_d;
  logic        fetch_valid_d, slot0_kill_d, flush_d, next_ds_d, ignored_d;

  logic        redirect_acc, branch_drop, fetch_acc, timer_zero;

  // BOOT never takes a redirect; the pipeline behind us holds nothing yet.
  assign redirect_acc = (i_branch_flag == BRANCH) && !i_is_in_delayslot && (state != ST_BOOT);
  assign branch_drop  = (i_branch_flag == BRANCH) &&  i_is_in_delayslot && (state != ST_BOOT);
  // Stall outranks the handshake: a stalled cycle never advances the PC.
  assign fetch_acc    = (state == ST_FETCH) && o_fetch_valid && i_fetch_ready && !i_stall;

  spu_flush_timer u_flush_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_acc),
    .load_val (FLUSH_LOAD),
    .dec      (state == ST_REDIRECT),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state               <= ST_BOOT;
      o_pc                <= RESET_PC;
      target_q            <= 32'h0;
      kill_pend_q         <= 1'b0;
      o_fetch_valid       <= 1'b0;
      o_slot0_kill        <= 1'b0;
      o_flush             <= 1'b0;
      o_next_in_delayslot <= 1'b0;
      o_branch_ignored    <= 1'b0;
    end else begin
      state               <= state_d;
      o_pc                <= pc_d;
      target_q            <= target_d;
      kill_pend_q         <= kill_pend_d;
      o_fetch_valid       <= fetch_valid_d;
      o_slot0_kill        <= slot0_kill_d;
      o_flush             <= flush_d;
      o_next_in_delayslot <= next_ds_d;
      o_branch_ignored    <= ignored_d;
    end
  end

  always_comb begin
    state_d       = state;
    pc_d          = o_pc;
    target_d      = target_q;
    kill_pend_d   = kill_pend_q;
    fetch_valid_d = o_fetch_valid;
    slot0_kill_d  = o_slot0_kill;
    flush_d       = o_flush;
    next_ds_d     = o_next_in_delayslot;
    ignored_d     = branch_drop;

    if (redirect_acc) begin
      // A new redirect (also one arriving mid-flush) replaces any pending
      // target and restarts the flush window; a same-cycle handshake is lost.
      state_d       = ST_REDIRECT;
      target_d      = i_branch_target_addr & ADDR_MASK;
      // Word-odd target ([0:31] bit 29): the even slot precedes the target.
      kill_pend_d   = i_branch_target_addr[2];
      flush_d       = 1'b1;
      fetch_valid_d = 1'b0;
      slot0_kill_d  = 1'b0;
      next_ds_d     = 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state_d       = ST_FETCH;
          fetch_valid_d = !i_stall;
        end
        ST_FETCH: begin
          fetch_valid_d = !i_stall;
          if (fetch_acc) begin
            pc_d         = (o_pc + 32'(FETCH_BYTES)) & ADDR_MASK;
            slot0_kill_d = 1'b0;
            next_ds_d    = 1'b0;
          end
        end
        ST_REDIRECT: begin
          // Timer runs regardless of stall; stall only gates the first request.
          if (timer_zero) begin
            state_d       = ST_FETCH;
            flush_d       = 1'b0;
            pc_d          = target_q;
            slot0_kill_d  = kill_pend_q;
            next_ds_d     = 1'b1;
            fetch_valid_d = !i_stall;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spu_pc_fetch_ctrl.sv
// Directed self-checking bench for spu_pc_fetch_ctrl.
// Latency: n/a.
// Backpressure: exercised through i_fetch_ready and i_stall.
module tb_spu_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        i_branch_flag;
  logic [31:0] i_branch_target_addr;
  logic        i_is_in_delayslot;
  logic        i_stall;
  logic        i_fetch_ready;
  logic        o_fetch_valid;
  logic [31:0] o_pc;
  logic        o_slot0_kill;
  logic        o_flush;
  logic        o_next_in_delayslot;
  logic        o_branch_ignored;

  int total;
  int bad;

  spu_pc_fetch_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_branch_flag        (i_branch_flag),
    .i_branch_target_addr (i_branch_target_addr),
    .i_is_in_delayslot    (i_is_in_delayslot),
    .i_stall              (i_stall),
    .i_fetch_ready        (i_fetch_ready),
    .o_fetch_valid        (o_fetch_valid),
    .o_pc                 (o_pc),
    .o_slot0_kill         (o_slot0_kill),
    .o_flush              (o_flush),
    .o_next_in_delayslot  (o_next_in_delayslot),
    .o_branch_ignored     (o_branch_ignored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst                  = 1'b1;
    i_branch_flag        = 1'b0;
    i_branch_target_addr = 32'h0;
    i_is_in_delayslot    = 1'b0;
    i_stall              = 1'b0;
    i_fetch_ready        = 1'b1;

    // Reset values
    tick();
    tick();
    chk    ("rst_pc",      o_pc, 32'h0);
    chk_bit("rst_valid",   o_fetch_valid, 1'b0);
    chk_bit("rst_flush",   o_flush, 1'b0);
    chk_bit("rst_kill",    o_slot0_kill, 1'b0);
    chk_bit("rst_nds",     o_next_in_delayslot, 1'b0);
    chk_bit("rst_ign",     o_branch_ignored, 1'b0);

    // Reset release: one BOOT cycle, then sequential fetches
    rst = 1'b0;
    tick();
    chk_bit("boot_exit_valid", o_fetch_valid, 1'b1);
    chk    ("seq_pc0",  o_pc, 32'h0);
    tick(); chk("seq_pc8",  o_pc, 32'h8);
    tick(); chk("seq_pc10", o_pc, 32'h10);
    tick(); chk("seq_pc18", o_pc, 32'h18);
    tick(); chk("seq_pc20", o_pc, 32'h20);

    // Local store not ready for 3 cycles at 0x20
    i_fetch_ready = 1'b0;
    tick(); chk("hold_pc_a", o_pc, 32'h20); chk_bit("hold_valid_a", o_fetch_valid, 1'b1);
    tick(); chk("hold_pc_b", o_pc, 32'h20);
    tick(); chk("hold_pc_c", o_pc, 32'h20); chk_bit("hold_valid_c", o_fetch_valid, 1'b1);
    i_fetch_ready = 1'b1;
    tick(); chk("resume_pc", o_pc, 32'h28);

    // Branch to 0x104 while a handshake is also accepted: target wins
    i_branch_flag = 1'b1;
    i_branch_target_addr = 32'h0000_0104;
    tick();
    i_branch_flag = 1'b0;
    chk_bit("br_flush_n1", o_flush, 1'b1);
    chk_bit("br_valid_n1", o_fetch_valid, 1'b0);
    tick(); chk_bit("br_flush_n2", o_flush, 1'b1);
    tick(); chk_bit("br_flush_n3", o_flush, 1'b1);
    tick();
    chk_bit("br_flush_n4", o_flush, 1'b0);
    chk    ("br_pc_n4",    o_pc, 32'h100);
    chk_bit("br_valid_n4", o_fetch_valid, 1'b1);
    chk_bit("br_kill_n4",  o_slot0_kill, 1'b1);
    chk_bit("br_nds_n4",   o_next_in_delayslot, 1'b1);
    tick();
    chk    ("br_pc_next",   o_pc, 32'h108);
    chk_bit("br_kill_clr",  o_slot0_kill, 1'b0);
    chk_bit("br_nds_clr",   o_next_in_delayslot, 1'b0);

    // Second branch during flush restarts the window
    i_branch_flag = 1'b1;
    i_branch_target_addr = 32'h0000_0104;
    tick();                                    // N+1
    i_branch_flag = 1'b0;
    tick();                                    // N+2
    i_branch_flag = 1'b1;
    i_branch_target_addr = 32'h0000_0200;
    tick();                                    // N+3
    i_branch_flag = 1'b0;
    chk_bit("rb_flush_n3", o_flush, 1'b1);
    tick(); chk_bit("rb_flush_n4", o_flush, 1'b1);
    chk_bit("rb_valid_n4", o_fetch_valid, 1'b0);
    tick(); chk_bit("rb_flush_n5", o_flush, 1'b1);
    tick();                                    // N+6
    chk_bit("rb_flush_n6", o_flush, 1'b0);
    chk    ("rb_pc_n6",    o_pc, 32'h200);
    chk_bit("rb_kill_n6",  o_slot0_kill, 1'b0);
    chk_bit("rb_valid_n6", o_fetch_valid, 1'b1);
    tick(); chk("rb_pc_next", o_pc, 32'h208);

    // Branch from a delay slot is dropped
    i_branch_flag = 1'b1;
    i_is_in_delayslot = 1'b1;
    i_branch_target_addr = 32'h0000_0500;
    tick();
    i_branch_flag = 1'b0;
    i_is_in_delayslot = 1'b0;
    chk_bit("ds_ign_pulse", o_branch_ignored, 1'b1);
    chk_bit("ds_no_flush",  o_flush, 1'b0);
    chk    ("ds_pc_a",      o_pc, 32'h210);
    tick();
    chk_bit("ds_ign_clr",   o_branch_ignored, 1'b0);
    chk    ("ds_pc_b",      o_pc, 32'h218);

    // Stall outranks a ready handshake
    i_stall = 1'b1;
    tick();
    chk    ("stall_pc",    o_pc, 32'h218);
    chk_bit("stall_valid", o_fetch_valid, 1'b0);
    i_stall = 1'b0;
    tick();
    chk    ("unstall_pc",    o_pc, 32'h218);
    chk_bit("unstall_valid", o_fetch_valid, 1'b1);
    tick(); chk("unstall_next", o_pc, 32'h220);

    // Branch to a masked target near top of LS, stall over the flush exit
    i_branch_flag = 1'b1;
    i_branch_target_addr = 32'hABC3_FFF9;
    tick();                                    // N+1
    i_branch_flag = 1'b0;
    tick();                                    // N+2
    tick();                                    // N+3
    i_stall = 1'b1;
    tick();                                    // N+4
    chk_bit("top_flush_done", o_flush, 1'b0);
    chk    ("top_pc",         o_pc, 32'h0003_FFF8);
    chk_bit("top_valid_stall", o_fetch_valid, 1'b0);
    chk_bit("top_kill",       o_slot0_kill, 1'b0);
    i_stall = 1'b0;
    tick();
    chk_bit("top_valid", o_fetch_valid, 1'b1);
    chk    ("top_pc_held", o_pc, 32'h0003_FFF8);
    tick();
    chk    ("wrap_pc", o_pc, 32'h0);
    tick();
    chk    ("wrap_pc_next", o_pc, 32'h8);

    // Reset in the middle of a flush discards the pending target
    i_branch_flag = 1'b1;
    i_branch_target_addr = 32'h0000_0800;
    tick();
    i_branch_flag = 1'b0;
    tick();
    chk_bit("mid_flush", o_flush, 1'b1);
    rst = 1'b1;
    tick();
    chk    ("mid_rst_pc",    o_pc, 32'h0);
    chk_bit("mid_rst_flush", o_flush, 1'b0);
    chk_bit("mid_rst_valid", o_fetch_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk    ("post_rst_pc",    o_pc, 32'h0);
    chk_bit("post_rst_valid", o_fetch_valid, 1'b1);
    chk_bit("post_rst_flush", o_flush, 1'b0);
    tick();
    chk    ("post_rst_pc8",   o_pc, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
